// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and flag record for the 8-bit ALU.
// Imported by the shifter and the top level.
package alu_pkg;

    localparam int unsigned DataW = 8;
    localparam int unsigned OpW   = 4;

    localparam logic [OpW-1:0] OP_ADD   = 4'h0;
    localparam logic [OpW-1:0] OP_SUB   = 4'h1;
    localparam logic [OpW-1:0] OP_AND   = 4'h2;
    localparam logic [OpW-1:0] OP_OR    = 4'h3;
    localparam logic [OpW-1:0] OP_XOR   = 4'h4;
    localparam logic [OpW-1:0] OP_NOT   = 4'h5;
    localparam logic [OpW-1:0] OP_SLL   = 4'h6;
    localparam logic [OpW-1:0] OP_SRL   = 4'h7;
    localparam logic [OpW-1:0] OP_SRA   = 4'h8;
    localparam logic [OpW-1:0] OP_ROL   = 4'h9;
    localparam logic [OpW-1:0] OP_ROR   = 4'hA;
    localparam logic [OpW-1:0] OP_SLT   = 4'hB;
    localparam logic [OpW-1:0] OP_SLTU  = 4'hC;
    localparam logic [OpW-1:0] OP_EQ    = 4'hD;
    localparam logic [OpW-1:0] OP_MUL   = 4'hE;
    localparam logic [OpW-1:0] OP_PASSB = 4'hF;

    // Bit positions inside the packed {C, Z, N, V} flag vector.
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 0;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } alu_flags_t;

    function automatic logic is_shift_op(input logic [OpW-1:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
               (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift/rotate unit: SLL, SRL, SRA, ROL, ROR by a 3-bit amount, plus the shift carry-out.
// Rotates report no carry; any non-shift opcode yields zero outputs.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [OpW-1:0]   op_i,
    input  logic [DataW-1:0] a_i,
    input  logic [2:0]       shamt_i,
    output logic [DataW-1:0] result_o,
    output logic             carry_o
);

    logic       shift_nz;
    logic [2:0] shamt_neg;

    assign shift_nz  = (shamt_i != 3'd0);
    // 8 - shamt modulo 8; used as the complementary distance for rotates and SLL carry.
    assign shamt_neg = 3'd0 - shamt_i;

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        unique case (op_i)
            OP_SLL: begin
                result_o = a_i << shamt_i;
                carry_o  = shift_nz & a_i[shamt_neg];
            end
            OP_SRL: begin
                result_o = a_i >> shamt_i;
                carry_o  = shift_nz & a_i[shamt_i - 3'd1];
            end
            OP_SRA: begin
                result_o = DataW'($signed(a_i) >>> shamt_i);
                carry_o  = shift_nz & a_i[shamt_i - 3'd1];
            end
            OP_ROL: begin
                result_o = (a_i << shamt_i) | (a_i >> shamt_neg);
            end
            OP_ROR: begin
                result_o = (a_i >> shamt_i) | (a_i << shamt_neg);
            end
            default: begin
                result_o = '0;
                carry_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// 8-bit ALU: combinational result F for 16 opcodes, with a registered {C, Z, N, V}
// flag bank captured on every rising clock edge and cleared by synchronous reset.
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [OpW-1:0]   instruction,
    input  logic [DataW-1:0] A,
    input  logic [DataW-1:0] B,
    output logic [DataW-1:0] F,
    output logic [3:0]       flags
);

    logic [DataW:0]     sum;
    logic [DataW:0]     diff;
    logic [2*DataW-1:0] prod;
    logic               add_ovf;
    logic               sub_ovf;
    logic               lt_signed;
    logic               lt_unsigned;
    logic               equal;
    logic [DataW-1:0]   shift_res;
    logic               shift_carry;

    logic [DataW-1:0]   result;
    logic               carry;
    logic               ovf;
    alu_flags_t         flags_d;
    alu_flags_t         flags_q;

    assign sum  = {1'b0, A} + {1'b0, B};
    // The ninth bit of the zero-extended difference is the unsigned borrow.
    assign diff = {1'b0, A} - {1'b0, B};
    assign prod = A * B;

    assign add_ovf = (A[DataW-1] == B[DataW-1]) && (sum[DataW-1] != A[DataW-1]);
    assign sub_ovf = (A[DataW-1] != B[DataW-1]) && (diff[DataW-1] != A[DataW-1]);

    assign lt_signed   = $signed(A) < $signed(B);
    assign lt_unsigned = A < B;
    assign equal       = A == B;

    alu_shifter u_shifter (
        .op_i     (instruction),
        .a_i      (A),
        .shamt_i  (B[2:0]),
        .result_o (shift_res),
        .carry_o  (shift_carry)
    );

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        unique case (instruction)
            OP_ADD: begin
                result = sum[DataW-1:0];
                carry  = sum[DataW];
                ovf    = add_ovf;
            end
            OP_SUB: begin
                result = diff[DataW-1:0];
                carry  = diff[DataW];
                ovf    = sub_ovf;
            end
            OP_AND:   result = A & B;
            OP_OR:    result = A | B;
            OP_XOR:   result = A ^ B;
            OP_NOT:   result = ~A;
            OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: begin
                result = shift_res;
                carry  = shift_carry;
            end
            OP_SLT:   result = {{(DataW-1){1'b0}}, lt_signed};
            OP_SLTU:  result = {{(DataW-1){1'b0}}, lt_unsigned};
            OP_EQ:    result = {{(DataW-1){1'b0}}, equal};
            OP_MUL: begin
                result = prod[DataW-1:0];
                carry  = |prod[2*DataW-1:DataW];
            end
            OP_PASSB: result = B;
            default: begin
                result = '0;
                carry  = 1'b0;
                ovf    = 1'b0;
            end
        endcase
    end

    always_comb begin
        flags_d   = '0;
        flags_d.c = carry;
        flags_d.z = (result == '0);
        flags_d.n = result[DataW-1];
        flags_d.v = ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign F     = result;
    assign flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, corner sequences,
// a 200-vector random sweep against a bit-serial golden model, and a reset check.
module tb_alu;

    logic       clk;
    logic       rst;
    logic [3:0] instruction;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] F;
    logic [3:0] flags;

    int checks;
    int errors;

    alu dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .A           (A),
        .B           (B),
        .F           (F),
        .flags       (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] f;
        logic [3:0] fl;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Independent reference: arithmetic in int, shifts/rotates one bit at a time.
    function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] f;
        logic       c;
        logic       v;
        int         sa;
        int         sb;
        int         r;
        int         sh;
        f  = 8'h00;
        c  = 1'b0;
        v  = 1'b0;
        sa = int'(a);
        sb = int'(b);
        if (a[7]) sa = sa - 256;
        if (b[7]) sb = sb - 256;
        sh = int'(b[2:0]);
        case (op)
            4'h0: begin
                r = int'(a) + int'(b);
                f = r[7:0];
                c = r > 255;
                r = sa + sb;
                v = (r > 127) || (r < -128);
            end
            4'h1: begin
                f = a - b;
                c = a < b;
                r = sa - sb;
                v = (r > 127) || (r < -128);
            end
            4'h2: f = a & b;
            4'h3: f = a | b;
            4'h4: f = a ^ b;
            4'h5: f = ~a;
            4'h6: begin
                f = a;
                for (int k = 0; k < sh; k++) begin c = f[7]; f = {f[6:0], 1'b0}; end
            end
            4'h7: begin
                f = a;
                for (int k = 0; k < sh; k++) begin c = f[0]; f = {1'b0, f[7:1]}; end
            end
            4'h8: begin
                f = a;
                for (int k = 0; k < sh; k++) begin c = f[0]; f = {f[7], f[7:1]}; end
            end
            4'h9: begin
                f = a;
                for (int k = 0; k < sh; k++) f = {f[6:0], f[7]};
            end
            4'hA: begin
                f = a;
                for (int k = 0; k < sh; k++) f = {f[0], f[7:1]};
            end
            4'hB: f = (sa < sb) ? 8'h01 : 8'h00;
            4'hC: f = (int'(a) < int'(b)) ? 8'h01 : 8'h00;
            4'hD: f = (a == b) ? 8'h01 : 8'h00;
            4'hE: begin
                r = int'(a) * int'(b);
                f = r[7:0];
                c = r > 255;
            end
            default: f = b;
        endcase
        return {f, c, (f == 8'h00), f[7], v};
    endfunction

    // Drive at the falling edge, check F mid-phase, check flags just after the rising edge.
    task automatic apply(input string name, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] ef, input logic [3:0] efl);
        @(negedge clk);
        instruction = op;
        A = a;
        B = b;
        #2;
        chk({name, ".F"}, F, ef);
        @(posedge clk);
        #1;
        chk({name, ".flags"}, {4'h0, flags}, {4'h0, efl});
    endtask

    initial begin
        logic [11:0] m;
        logic [3:0]  rop;
        logic [7:0]  ra;
        logic [7:0]  rb;
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        instruction = 4'h0;
        A           = 8'hFF;
        B           = 8'h01;

        // Reset state: flags cleared even though ADD FF+01 would set C and Z.
        repeat (2) @(posedge clk);
        #1;
        chk("reset.flags", {4'h0, flags}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        //           op     A      B      F      {C,Z,N,V}
        vecs.push_back('{4'h0, 8'hFF, 8'h01, 8'h00, 4'b1100}); // ADD wrap
        vecs.push_back('{4'h1, 8'h80, 8'h01, 8'h7F, 4'b0001}); // SUB overflow
        vecs.push_back('{4'h8, 8'h90, 8'h0A, 8'hE4, 4'b0010}); // SRA by 2
        vecs.push_back('{4'h7, 8'h90, 8'h0A, 8'h24, 4'b0000}); // SRL by 2
        vecs.push_back('{4'hA, 8'h01, 8'h01, 8'h80, 4'b0010}); // ROR 1
        vecs.push_back('{4'hB, 8'hFE, 8'h01, 8'h01, 4'b0000}); // SLT signed
        vecs.push_back('{4'hC, 8'hFE, 8'h01, 8'h00, 4'b0100}); // SLTU
        vecs.push_back('{4'hD, 8'h5A, 8'h5A, 8'h01, 4'b0000}); // EQ
        vecs.push_back('{4'hE, 8'h10, 8'h11, 8'h10, 4'b1000}); // MUL high byte
        vecs.push_back('{4'h5, 8'h0F, 8'h99, 8'hF0, 4'b0010}); // NOT
        vecs.push_back('{4'hF, 8'h77, 8'h3C, 8'h3C, 4'b0000}); // PASSB
        vecs.push_back('{4'h0, 8'h7F, 8'h01, 8'h80, 4'b0011}); // ADD overflow
        vecs.push_back('{4'h1, 8'h01, 8'h02, 8'hFF, 4'b1010}); // SUB borrow
        vecs.push_back('{4'h6, 8'h81, 8'h01, 8'h02, 4'b1000}); // SLL carry
        vecs.push_back('{4'h6, 8'h81, 8'h08, 8'h81, 4'b0010}); // SLL by 0, B[3] ignored
        vecs.push_back('{4'h8, 8'h81, 8'h01, 8'hC0, 4'b1010}); // SRA carry
        vecs.push_back('{4'h9, 8'h81, 8'h0B, 8'h0C, 4'b0000}); // ROL 3
        vecs.push_back('{4'h2, 8'hF0, 8'h3C, 8'h30, 4'b0000}); // AND
        vecs.push_back('{4'h3, 8'hF0, 8'h0F, 8'hFF, 4'b0010}); // OR
        vecs.push_back('{4'h4, 8'hAA, 8'hAA, 8'h00, 4'b0100}); // XOR zero
        vecs.push_back('{4'hB, 8'h01, 8'hFE, 8'h00, 4'b0100}); // SLT false

        foreach (vecs[i]) begin
            apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].f, vecs[i].fl);
        end

        // Back-to-back: flags must follow the new op after one edge, not hold old ones.
        apply("seq.add", 4'h0, 8'hFF, 8'h01, 8'h00, 4'b1100);
        apply("seq.pass", 4'hF, 8'h00, 8'h01, 8'h01, 4'b0000);

        for (int i = 0; i < 200; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            m   = model(rop, ra, rb);
            apply($sformatf("rnd%0d.op%0h", i, rop), rop, ra, rb, m[11:4], m[3:0]);
        end

        // Reset for one edge with flag-setting inputs; F keeps tracking inputs.
        apply("prerst", 4'h0, 8'hFF, 8'h01, 8'h00, 4'b1100);
        @(negedge clk);
        rst         = 1'b1;
        instruction = 4'h1;
        A           = 8'h01;
        B           = 8'h02;
        #2;
        chk("rst.F", F, 8'hFF);
        @(posedge clk);
        #1;
        chk("rst.flags", {4'h0, flags}, 8'h00);
        A = 8'h05;
        #1;
        chk("rst.Ftrack", F, 8'h03);
        @(negedge clk);
        rst = 1'b0;
        apply("postrst", 4'h1, 8'h01, 8'h02, 8'hFF, 4'b1010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
